// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares one combinational program-ROM read port between the instruction
// fetch unit (port 0) and the debug/loader port (port 1). Fetch has priority,
// but debug is forced through after MAX_WAIT consecutive lost cycles.
// Each grant produces a one-cycle registered response on the winning port,
// with out-of-range addresses returning zero data and an error flag.
// A saturating counter records how many cycles both ports requested.

module rom_port_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 1024,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_valid,
   output logic [DATA_W-1:0] f_data,
   output logic              f_err,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_data,
   output logic              d_err,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              cnt_clr,
   output logic [15:0]       conflict_cnt
);

   localparam int NP = 2;
   // One extra bit so a DEPTH equal to the full address space still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_X    = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      MAX_WAIT_X = 4'(MAX_WAIT);

   logic [NP-1:0]     req;
   logic [ADDR_W-1:0] addr [NP];
   logic [NP-1:0]     gnt;
   logic [NP-1:0]     oor;

   logic              valid_reg [NP];
   logic [DATA_W-1:0] data_reg  [NP];
   logic              err_reg   [NP];

   logic [3:0]  wcnt_reg, wcnt_next;
   logic        force_d;
   logic [15:0] conflict_reg, conflict_next;

   assign req     = {d_req, f_req};
   assign addr[0] = f_addr;
   assign addr[1] = d_addr;

   // Debug has waited long enough: it takes the next contended cycle.
   assign force_d = (wcnt_reg == MAX_WAIT_X);

   // Grant decision: a lone requester wins, fetch wins contention unless debug is forced; nothing during reset.
   always_comb begin
      gnt = '0;
      if (rst_n) begin
         if (f_req && d_req) begin
            if (force_d) begin
               gnt[1] = 1'b1;
            end else begin
               gnt[0] = 1'b1;
            end
         end else begin
            gnt = req;
         end
      end
   end

   // ROM address follows the winner, zero when idle.
   always_comb begin
      rom_addr = '0;
      if (gnt[0]) begin
         rom_addr = f_addr;
      end else if (gnt[1]) begin
         rom_addr = d_addr;
      end
   end

   // Per-port response registers; only the granted port captures, the other drops valid and holds data/err.
   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_port
         // Full-width range check, no truncation to the ROM index width.
         assign oor[gi] = ({1'b0, addr[gi]} >= DEPTH_X);

         // Capture the ROM word (or zero on out-of-range) on a grant edge.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_reg[gi] <= 1'b0;
               data_reg[gi]  <= '0;
               err_reg[gi]   <= 1'b0;
            end else if (gnt[gi]) begin
               valid_reg[gi] <= 1'b1;
               data_reg[gi]  <= oor[gi] ? '0 : rom_data;
               err_reg[gi]   <= oor[gi];
            end else begin
               valid_reg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   assign f_gnt   = gnt[0];
   assign d_gnt   = gnt[1];
   assign f_valid = valid_reg[0];
   assign f_data  = data_reg[0];
   assign f_err   = err_reg[0];
   assign d_valid = valid_reg[1];
   assign d_data  = data_reg[1];
   assign d_err   = err_reg[1];

   // Debug wait counter: cleared on a debug grant or when debug is idle, saturating while debug loses.
   always_comb begin
      wcnt_next = wcnt_reg;
      if (gnt[1]) begin
         wcnt_next = 4'd0;
      end else if (d_req) begin
         if (wcnt_reg != MAX_WAIT_X) begin
            wcnt_next = wcnt_reg + 4'd1;
         end
      end else begin
         wcnt_next = 4'd0;
      end
   end

   // Contention profiling counter: clear wins over increment, saturates at all-ones.
   always_comb begin
      conflict_next = conflict_reg;
      if (cnt_clr) begin
         conflict_next = 16'd0;
      end else if (f_req && d_req && (conflict_reg != 16'hFFFF)) begin
         conflict_next = conflict_reg + 16'd1;
      end
   end

   // Arbitration and profiling state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_reg     <= 4'd0;
         conflict_reg <= 16'd0;
      end else begin
         wcnt_reg     <= wcnt_next;
         conflict_reg <= conflict_next;
      end
   end

   assign conflict_cnt = conflict_reg;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter: directed stimulus pushes expected responses
// into per-port queues; a monitor pops and compares on every valid response.

module tb_rom_port_arbiter;

   typedef struct packed {
      logic [15:0] data;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        f_req = 1'b0;
   logic [15:0] f_addr = '0;
   logic        f_gnt, f_valid, f_err;
   logic [15:0] f_data;
   logic        d_req = 1'b0;
   logic [15:0] d_addr = '0;
   logic        d_gnt, d_valid, d_err;
   logic [15:0] d_data;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic        cnt_clr = 1'b0;
   logic [15:0] conflict_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   rsp_t f_q[$];
   rsp_t d_q[$];

   rom_port_arbiter #(
      .ADDR_W(16), .DATA_W(16), .DEPTH(1024), .MAX_WAIT(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
      .f_valid(f_valid), .f_data(f_data), .f_err(f_err),
      .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
      .d_valid(d_valid), .d_data(d_data), .d_err(d_err),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // ROM model: a few fixed words, a simple pattern elsewhere, garbage beyond the array.
   function automatic logic [15:0] rom_word(input logic [15:0] a);
      if (a == 16'd1)       return 16'h008D;
      else if (a == 16'd2)  return 16'h0004;
      else if (a == 16'd3)  return 16'hE08E;
      else if (a >= 16'd1024) return 16'hDEAD;
      else                  return a ^ 16'hA5A5;
   endfunction

   always_comb rom_data = rom_word(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus: drive, check grant and ROM address, queue the expected response.
   task automatic step(input logic fr, input logic [15:0] fa, input logic dr, input logic [15:0] da,
                       input logic cl, input logic efg, input logic edg, input logic [15:0] erom,
                       input logic [15:0] edata, input logic eerr);
      rsp_t r;
      @(posedge clk);
      #1;
      f_req = fr; f_addr = fa; d_req = dr; d_addr = da; cnt_clr = cl;
      #1;
      chk("f_gnt", {31'd0, f_gnt}, {31'd0, efg});
      chk("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
      chk("rom_addr", {16'd0, rom_addr}, {16'd0, erom});
      r.data = edata;
      r.err  = eerr;
      if (efg) f_q.push_back(r);
      if (edg) d_q.push_back(r);
      $display("step f_req=%b f_addr=%h d_req=%b d_addr=%h gnt=%b%b rom_addr=%h cnt=%h",
               fr, fa, dr, da, f_gnt, d_gnt, rom_addr, conflict_cnt);
   endtask

   task automatic idle();
      step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
   endtask

   // Monitor: every valid response must match the head of its port's queue.
   always @(negedge clk) begin
      rsp_t e;
      if (f_valid) begin
         if (f_q.size() == 0) begin
            chk("f_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = f_q.pop_front();
            chk("f_data", {16'd0, f_data}, {16'd0, e.data});
            chk("f_err", {31'd0, f_err}, {31'd0, e.err});
         end
      end
      if (d_valid) begin
         if (d_q.size() == 0) begin
            chk("d_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = d_q.pop_front();
            chk("d_data", {16'd0, d_data}, {16'd0, e.data});
            chk("d_err", {31'd0, d_err}, {31'd0, e.err});
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic dwin;
      // Power-on reset state.
      #3;
      chk("rst_f_valid", {31'd0, f_valid}, 32'd0);
      chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
      chk("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
      chk("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
      #9 rst_n = 1'b1;

      // Single fetch and back-to-back fetches.
      step(1'b1, 16'd1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd1, 16'h008D, 1'b0);
      step(1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2, 16'h0004, 1'b0);
      step(1'b1, 16'd3, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd3, 16'hE08E, 1'b0);
      idle();
      idle();
      chk("f_valid_drop", {31'd0, f_valid}, 32'd0);
      chk("f_data_hold", {16'd0, f_data}, 32'h0000E08E);

      // Contention: fetch wins 4 cycles, debug forced on the 5th, repeating.
      for (int i = 0; i < 10; i++) begin
         dwin = (i % 5 == 4);
         step(1'b1, 16'd1, 1'b1, 16'd3, 1'b0, !dwin, dwin, dwin ? 16'd3 : 16'd1,
              dwin ? 16'hE08E : 16'h008D, 1'b0);
      end
      idle();
      chk("conflict_10", {16'd0, conflict_cnt}, 32'd10);

      // Range boundary on the debug port, then fetch; debug data/err must hold.
      step(1'b0, 16'd0, 1'b1, 16'd1023, 1'b0, 1'b0, 1'b1, 16'd1023, 16'hA65A, 1'b0);
      step(1'b0, 16'd0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
      step(1'b0, 16'd0, 1'b1, 16'd1024, 1'b0, 1'b0, 1'b1, 16'd1024, 16'h0000, 1'b1);
      step(1'b1, 16'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 16'hA5A5, 1'b0);
      step(1'b1, 16'h0400, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1);
      idle();
      chk("d_valid_drop", {31'd0, d_valid}, 32'd0);
      chk("d_err_hold", {31'd0, d_err}, 32'd1);
      chk("d_data_hold", {16'd0, d_data}, 32'd0);
      chk("conflict_still_10", {16'd0, conflict_cnt}, 32'd10);

      // Asynchronous reset mid-cycle while a fetch is granted; its response is dropped.
      step(1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2, 16'h0004, 1'b0);
      @(posedge clk);
      #1;
      f_req = 1'b1; f_addr = 16'd1;
      #1;
      chk("pre_rst_f_valid", {31'd0, f_valid}, 32'd1);
      chk("pre_rst_f_gnt", {31'd0, f_gnt}, 32'd1);
      f_q.delete();
      d_q.delete();
      rst_n = 1'b0;
      #1;
      chk("arst_f_valid", {31'd0, f_valid}, 32'd0);
      chk("arst_f_data", {16'd0, f_data}, 32'd0);
      chk("arst_d_err", {31'd0, d_err}, 32'd0);
      chk("arst_f_gnt", {31'd0, f_gnt}, 32'd0);
      chk("arst_rom_addr", {16'd0, rom_addr}, 32'd0);
      chk("arst_conflict", {16'd0, conflict_cnt}, 32'd0);
      $display("async reset applied with f_req=1");
      @(posedge clk);
      #1;
      chk("rst_hold_f_gnt", {31'd0, f_gnt}, 32'd0);
      chk("rst_hold_f_valid", {31'd0, f_valid}, 32'd0);
      #1;
      f_req = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      chk("post_rst_f_valid", {31'd0, f_valid}, 32'd0);

      // Saturation: 70000 contended cycles, then clear concurrent with contention.
      for (int i = 0; i < 70001; i++) begin
         dwin = (i % 5 == 4);
         step(1'b1, 16'd1, 1'b1, 16'd3, (i == 70000), !dwin, dwin, dwin ? 16'd3 : 16'd1,
              dwin ? 16'hE08E : 16'h008D, 1'b0);
         if (i == 69999) chk("conflict_sat", {16'd0, conflict_cnt}, 32'h0000FFFF);
      end
      idle();
      chk("conflict_clr", {16'd0, conflict_cnt}, 32'd0);
      idle();
      chk("f_q_drained", f_q.size(), 32'd0);
      chk("d_q_drained", d_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
